nbit_accumulator: RTL and testbench
===================================

# nbit_accumulator

Sequential accumulation stage that sits directly around the n-bit adder in the matrix multiplier datapath. It accepts a stream of MSB-bit terms (row×column partial products) over a valid/ready handshake. It drives the adder's A (running sum) and B (incoming term) operands and registers the adder's Sum/Carry each accepted cycle. After NTERMS terms it presents one dot-product result downstream with a sticky overflow flag.

## Interface
- MSB, project_pkg::MSB (8): data width of terms, adder operands and result.
- NTERMS, project_pkg::NTERMS (4): terms summed per result; legal range 1..2^CW-1, where CW = $clog2(NTERMS+1).
- clk  input  1  rising-edge clock; the block's only clock.
- rst_n  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous abort; discards the partial sum.
- in_valid  input  1  in_data holds a term.
- in_ready  output  1  block can accept a term this cycle.
- in_data  input  MSB  term to add.
- out_valid  output  1  out_sum/out_ovf hold a completed result.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  MSB  accumulated sum, modulo 2^MSB.
- out_ovf  output  1  sticky: adder Carry was 1 on at least one accepted term of this result.

## Operation
- States (acc_state_t):
  - IDLE: acc=0, cnt=0, in_ready=1.
  - ACCUM: in_ready=1, 1≤cnt<NTERMS.
  - DONE: in_ready=0, out_valid=1.
- Adder hookup is combinational: A=acc, B=in_data. Term accepted when in_valid && in_ready.
  - On accept: acc←Sum, ovf←ovf|Carry, cnt←cnt+1.
  - In IDLE, acc=0 and ovf=0, so the first term loads unchanged with Carry=0.
- Transitions:
  - IDLE→ACCUM on accept, when NTERMS>1.
  - IDLE→DONE on accept, when NTERMS=1.
  - ACCUM→DONE on the accept that makes cnt=NTERMS.
  - ACCUM holds when in_valid=0. No timeout; acc/cnt/ovf are held.
  - DONE→IDLE on out_valid && out_ready. acc, cnt and ovf clear in the same edge.
- out_sum=acc and out_ovf=ovf, registered. Both hold stable while out_valid=1 && out_ready=0.
- Arithmetic: unsigned, wrap modulo 2^MSB. No saturation; overflow is reported only through out_ovf.
- clr (sync, any state): next state IDLE, acc/cnt/ovf←0. clr has priority over a simultaneous accept or output handshake. A term presented in a clr cycle is not consumed, and an output handshake in a clr cycle does not complete.
- rst_n low (async, any state, including mid-accumulation): immediately state=IDLE, acc=0, cnt=0, ovf=0.

## Timing
- Reset values: in_ready=1, out_valid=0, out_sum=0, out_ovf=0.
- Throughput: one term per cycle in IDLE/ACCUM.
- Latency: out_valid asserts the cycle after the NTERMS-th accept.
- The result sits in DONE for at least 1 cycle. in_ready=0 for every cycle in DONE.
- Back-to-back results: earliest next accept is the cycle after the output handshake (IDLE). Minimum period is NTERMS+1 cycles.
- in_ready depends only on state, never on in_valid. out_valid depends only on state, never on out_ready. No combinational in→out paths except the adder through acc next-state.
- Handshake rule: upstream must hold in_data stable while in_valid=1 && in_ready=0.

## Structure
- project_pkg (package.sv) holds:
  - MSB, already present.
  - NTERMS (default 4).
  - typedef enum logic [1:0] {IDLE, ACCUM, DONE} acc_state_t.
- One sub-module, natural and required: nbit_adder, instantiated through intf_nbitAdder using its dut modport. The accumulator drives A/B and reads Sum/Carry from the same interface instance.
- Counter width CW = $clog2(NTERMS+1), a localparam.

## Test plan
- Reset mid-accumulation: MSB=8, NTERMS=4; accept 3,5; pulse rst_n low asynchronously between edges.
  - Required: outputs drop at once to in_ready=1, out_valid=0, out_sum=0.
  - Next terms 1,1,1,1 give out_sum=4.
- Basic sum: terms 10,20,30,40 back-to-back, out_ready=1.
  - Required: out_valid=1 exactly one cycle after the 4th accept, with out_sum=100, out_ovf=0. IDLE on the following cycle.
- Overflow wrap: terms 200,100,1,0.
  - Required: out_sum=45 (301 mod 256), out_ovf=1.
  - The next result from 1,1,1,1 gives out_ovf=0 (sticky flag cleared per result).
- Backpressure and bubbles:
  - Terms 1,2,3,4 with in_valid gaps. Required: cnt advances only on accepts.
  - out_ready=0 for 5 cycles. Required: out_sum=10 held stable, in_ready=0 throughout, exactly one result consumed.
- clr collisions:
  - clr asserted with in_valid=1 after 2 accepts (7,8). Required: term not consumed, IDLE next cycle; the next 4 terms 1,1,1,1 give 4.
  - clr asserted together with the out_ready handshake in DONE. Required: result dropped, IDLE next cycle.
- NTERMS=1 build: each accepted term x appears as out_sum=x one cycle later. Periodic accepts occur every 2 cycles with out_ready=1.

Source files
------------

// File: rtl/package.sv
`default_nettype none
// ============================================================================
// project_pkg : shared widths and state encoding for the accumulator slice
// Revision    : 1.0
// ============================================================================
package project_pkg;
    localparam int MSB    = 8;
    localparam int NTERMS = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } acc_state_t;
endpackage
`default_nettype wire

// File: rtl/intf_nbitAdder.sv
`default_nettype none
// ============================================================================
// intf_nbitAdder : operand/result bundle between the accumulator and its adder
// Revision       : 1.0
// ============================================================================
interface intf_nbitAdder #(
    parameter int MSB = project_pkg::MSB
);
    logic [MSB-1:0] A;
    logic [MSB-1:0] B;
    logic [MSB-1:0] Sum;
    logic           Carry;

    modport dut (input A, input B, output Sum, output Carry);
    modport drv (output A, output B, input Sum, input Carry);
endinterface
`default_nettype wire

// File: rtl/nbit_accumulator_if.sv
`default_nettype none
// ============================================================================
// nbit_accumulator_if : term stream in, dot-product result out
// Revision            : 1.0
// ============================================================================
interface nbit_accumulator_if #(
    parameter int MSB = project_pkg::MSB
);
    logic           in_valid;
    logic           in_ready;
    logic [MSB-1:0] in_data;
    logic           out_valid;
    logic           out_ready;
    logic [MSB-1:0] out_sum;
    logic           out_ovf;

    modport master (
        output in_valid, output in_data, output out_ready,
        input  in_ready, input  out_valid, input  out_sum, input out_ovf
    );
    modport slave (
        input  in_valid, input  in_data, input  out_ready,
        output in_ready, output out_valid, output out_sum, output out_ovf
    );
endinterface
`default_nettype wire

// File: rtl/nbit_adder.sv
`default_nettype none
// ============================================================================
// nbit_adder : unsigned MSB-bit ripple adder with carry out
// Revision   : 1.0
// ============================================================================
module nbit_adder #(
    parameter int MSB = project_pkg::MSB
) (
    intf_nbitAdder.dut bus
);
    logic [MSB:0] full_sum;

    assign full_sum  = {1'b0, bus.A} + {1'b0, bus.B};
    assign bus.Sum   = full_sum[MSB-1:0];
    assign bus.Carry = full_sum[MSB];
endmodule
`default_nettype wire

// File: rtl/nbit_accumulator.sv
`default_nettype none
// ============================================================================
// nbit_accumulator : sums NTERMS streamed terms, emits sum + sticky overflow
// Revision         : 1.0
// ============================================================================
module nbit_accumulator
    import project_pkg::*;
#(
    parameter int MSB    = project_pkg::MSB,
    parameter int NTERMS = project_pkg::NTERMS
) (
    input  wire               clk,
    input  wire               rst_n,
    input  wire               clr,
    nbit_accumulator_if.slave io
);
    localparam int CW = $clog2(NTERMS + 1);

    acc_state_t     state;
    logic [MSB-1:0] acc;
    logic [CW-1:0]  cnt;
    logic           ovf;
    logic           in_ready_q;
    logic           out_valid_q;
    logic           accept;

    intf_nbitAdder #(.MSB(MSB)) add_bus ();

    nbit_adder #(.MSB(MSB)) u_adder (
        .bus (add_bus.dut)
    );

    assign add_bus.A = acc;
    assign add_bus.B = io.in_data;

    assign accept       = io.in_valid && in_ready_q;
    assign io.in_ready  = in_ready_q;
    assign io.out_valid = out_valid_q;
    assign io.out_sum   = acc;
    assign io.out_ovf   = ovf;

    // Handshake flags are kept as their own flops so they never decode from inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            acc         <= '0;
            cnt         <= '0;
            ovf         <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else if (clr) begin
            state       <= IDLE;
            acc         <= '0;
            cnt         <= '0;
            ovf         <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        acc <= add_bus.Sum;
                        ovf <= ovf | add_bus.Carry;
                        cnt <= cnt + CW'(1);
                        if (cnt == CW'(NTERMS - 1)) begin
                            state       <= DONE;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else begin
                            state       <= ACCUM;
                        end
                    end
                end
                DONE: begin
                    if (io.out_ready) begin
                        state       <= IDLE;
                        acc         <= '0;
                        cnt         <= '0;
                        ovf         <= 1'b0;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    acc         <= '0;
                    cnt         <= '0;
                    ovf         <= 1'b0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_nbit_accumulator.sv
`default_nettype none
// ============================================================================
// tb_nbit_accumulator : table, directed and random checks for NTERMS=4 and 1
// Revision            : 1.0
// ============================================================================
module tb_nbit_accumulator;
    logic clk;
    logic rst_n;
    logic clr4;
    logic clr1;

    int checks = 0;
    int errors = 0;

    nbit_accumulator_if #(.MSB(8)) a ();
    nbit_accumulator_if #(.MSB(8)) b ();

    nbit_accumulator #(.MSB(8), .NTERMS(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr4),
        .io    (a.slave)
    );

    nbit_accumulator #(.MSB(8), .NTERMS(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr1),
        .io    (b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0][7:0] t;
        int              gap;
        int              hold;
        logic [7:0]      sum;
        logic            ovf;
    } vec_t;

    function automatic vec_t mk(input int t0, input int t1, input int t2, input int t3,
                                input int gap, input int hold, input int sum, input int ovf);
        vec_t v;
        v.t[0] = 8'(t0); v.t[1] = 8'(t1); v.t[2] = 8'(t2); v.t[3] = 8'(t3);
        v.gap  = gap;
        v.hold = hold;
        v.sum  = 8'(sum);
        v.ovf  = 1'(ovf);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_term(input logic [7:0] d, input int gap);
        int n;
        a.in_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            tick();
            check("gap_no_result", 32'(a.out_valid), 32'd0);
        end
        a.in_valid = 1'b1;
        a.in_data  = d;
        n = 0;
        while (!a.in_ready && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) check("in_ready_timeout", 32'(a.in_ready), 32'd1);
        tick();
        a.in_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string name);
        a.out_ready = (v.hold == 0);
        for (int k = 0; k < 4; k++) send_term(v.t[k], v.gap);
        check({name, "_valid"}, 32'(a.out_valid), 32'd1);
        check({name, "_sum"},   32'(a.out_sum),   32'(v.sum));
        check({name, "_ovf"},   32'(a.out_ovf),   32'(v.ovf));
        check({name, "_inrdy"}, 32'(a.in_ready),  32'd0);
        for (int h = 0; h < v.hold; h++) begin
            tick();
            check({name, "_hold_valid"}, 32'(a.out_valid), 32'd1);
            check({name, "_hold_sum"},   32'(a.out_sum),   32'(v.sum));
            check({name, "_hold_inrdy"}, 32'(a.in_ready),  32'd0);
        end
        a.out_ready = 1'b1;
        tick();
        a.out_ready = 1'b0;
        check({name, "_idle_valid"}, 32'(a.out_valid), 32'd0);
        check({name, "_idle_inrdy"}, 32'(a.in_ready),  32'd1);
    endtask

    vec_t tbl[6];

    initial begin
        vec_t       v;
        int         total;
        logic [7:0] d;

        rst_n = 1'b0; clr4 = 1'b0; clr1 = 1'b0;
        a.in_valid = 1'b0; a.in_data = '0; a.out_ready = 1'b0;
        b.in_valid = 1'b0; b.in_data = '0; b.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        check("rst_in_ready",  32'(a.in_ready),  32'd1);
        check("rst_out_valid", 32'(a.out_valid), 32'd0);
        check("rst_out_sum",   32'(a.out_sum),   32'd0);
        check("rst_out_ovf",   32'(a.out_ovf),   32'd0);

        // Asynchronous reset in the middle of a result
        send_term(8'd3, 0);
        send_term(8'd5, 0);
        check("pre_rst_partial", 32'(a.out_sum), 32'd8);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_in_ready",  32'(a.in_ready),  32'd1);
        check("async_rst_out_valid", 32'(a.out_valid), 32'd0);
        check("async_rst_out_sum",   32'(a.out_sum),   32'd0);
        #1 rst_n = 1'b1;
        tick();
        run_vec(mk(1, 1, 1, 1, 0, 0, 4, 0), "after_rst");

        tbl[0] = mk(10, 20, 30, 40, 0, 0, 100, 0);
        tbl[1] = mk(200, 100, 1, 0, 0, 0, 45, 1);
        tbl[2] = mk(1, 1, 1, 1, 0, 0, 4, 0);
        tbl[3] = mk(1, 2, 3, 4, 2, 5, 10, 0);
        tbl[4] = mk(255, 255, 255, 255, 1, 2, 252, 1);
        tbl[5] = mk(0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 6; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

        // clr with a term on the bus after two accepts
        send_term(8'd7, 0);
        send_term(8'd8, 0);
        a.in_valid = 1'b1; a.in_data = 8'd99; clr4 = 1'b1;
        tick();
        clr4 = 1'b0; a.in_valid = 1'b0;
        check("clr_in_idle_sum",   32'(a.out_sum),  32'd0);
        check("clr_in_idle_inrdy", 32'(a.in_ready), 32'd1);
        run_vec(mk(1, 1, 1, 1, 0, 0, 4, 0), "after_clr_in");

        // clr colliding with the output handshake
        a.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) send_term(8'(5 + k), 0);
        check("clr_out_pre_valid", 32'(a.out_valid), 32'd1);
        check("clr_out_pre_sum",   32'(a.out_sum),   32'd26);
        clr4 = 1'b1; a.out_ready = 1'b1;
        tick();
        clr4 = 1'b0; a.out_ready = 1'b0;
        check("clr_out_valid", 32'(a.out_valid), 32'd0);
        check("clr_out_inrdy", 32'(a.in_ready),  32'd1);
        check("clr_out_sum",   32'(a.out_sum),   32'd0);
        run_vec(mk(1, 1, 1, 1, 0, 0, 4, 0), "after_clr_out");

        // Random results against plain-arithmetic model
        for (int r = 0; r < 16; r++) begin
            total = 0;
            for (int k = 0; k < 4; k++) begin
                d = 8'($urandom_range(0, (r % 2 == 1) ? 255 : 60));
                v.t[k] = d;
                total += int'(d);
            end
            v.gap  = int'($urandom_range(0, 2));
            v.hold = int'($urandom_range(0, 3));
            v.sum  = 8'(total % 256);
            v.ovf  = (total >= 256);
            run_vec(v, $sformatf("rnd%0d", r));
        end

        // NTERMS=1 instance: one result per two cycles with steady valid/ready
        b.in_valid  = 1'b1;
        b.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            d = 8'($urandom_range(0, 255));
            b.in_data = d;
            check("n1_in_ready", 32'(b.in_ready), 32'd1);
            tick();
            check("n1_out_valid", 32'(b.out_valid), 32'd1);
            check("n1_out_sum",   32'(b.out_sum),   32'(d));
            check("n1_out_ovf",   32'(b.out_ovf),   32'd0);
            check("n1_busy",      32'(b.in_ready),  32'd0);
            tick();
            check("n1_idle_valid", 32'(b.out_valid), 32'd0);
        end
        b.in_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: actual=timeout expected=finish");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
